// File: rtl/fp_alu_seq.sv
// fp_alu_seq: single-requester sequencer in front of the FP ALU.
// Holds op/operands on the ALU, waits on Done for sine, returns results.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_op, req_a, req_b payload
//   resp_valid/resp_ready response handshake; resp_res, resp_err payload
//   alu_op/alu_a/alu_b   registered ALU inputs, held for the whole op
//   alu_res/alu_done     ALU result and Done flag (Done used for sine only)
//   busy                 sequencer not idle
//   cycles               WAIT cycles of the last completed op
module fp_alu_seq #(
    parameter int          SIN_SETTLE   = 2,
    parameter int          TIMEOUT      = 1023,
    parameter logic [7:0]  ILLEGAL_MASK = 8'b1100_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_res,
    output logic        resp_err,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_done,
    output logic        busy,
    output logic [9:0]  cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_SIN = 3'd5;
    localparam logic [9:0] SETTLE = 10'(SIN_SETTLE);
    localparam logic [9:0] TMO    = 10'(TIMEOUT);

    state_t     state;
    logic [9:0] timer;
    logic [9:0] timer_nxt;

    // timer_nxt is the count of WAIT cycles including the current one,
    // so the first WAIT cycle sees 1 and a stale Done there is ignored.
    assign timer_nxt = timer + 10'd1;

    // req_ready is gated by rst so it reads 0 while reset is held.
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_op   <= 3'd0;
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            resp_res <= 32'd0;
            resp_err <= 1'b0;
            cycles   <= 10'd0;
            timer    <= 10'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (ILLEGAL_MASK[req_op]) begin
                            // ALU inputs left untouched for illegal ops
                            resp_res <= 32'd0;
                            resp_err <= 1'b1;
                            cycles   <= 10'd0;
                            state    <= RESP;
                        end else begin
                            alu_op <= req_op;
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (alu_op != OP_SIN) begin
                        resp_res <= alu_res;
                        resp_err <= 1'b0;
                        cycles   <= 10'd0;
                        state    <= RESP;
                    end else begin
                        timer <= 10'd0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer_nxt;
                    if (timer_nxt >= SETTLE && alu_done) begin
                        resp_res <= alu_res;
                        resp_err <= 1'b0;
                        cycles   <= timer_nxt;
                        state    <= RESP;
                    end else if (timer_nxt >= TMO) begin
                        resp_res <= 32'd0;
                        resp_err <= 1'b1;
                        cycles   <= 10'd1023;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed self-checking bench for fp_alu_seq.
// The bench plays the ALU, driving alu_res/alu_done by hand.
module tb_fp_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_res;
    logic        resp_err;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_done;
    logic        busy;
    logic [9:0]  cycles;

    int n_tests = 0;
    int n_fail  = 0;

    fp_alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_err   (resp_err),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .alu_done   (alu_done),
        .busy       (busy),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    int  cnt;
    bit  seen;
    logic [31:0] held;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        alu_res    = 32'd0;
        alu_done   = 1'b1;
        tick();
        tick();
        chk("rdy_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(req_ready), 32'd1);
        chk("rst_vld", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", resp_res, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_cyc", 32'(cycles), 32'd0);

        // add 1.0 + 2.0
        alu_res = 32'h4040_0000;
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000);
        chk("add_exec_vld", 32'(resp_valid), 32'd0);
        chk("add_exec_rdy", 32'(req_ready), 32'd0);
        chk("add_alu_a", alu_a, 32'h3F80_0000);
        chk("add_alu_b", alu_b, 32'h4000_0000);
        tick();
        chk("add_vld", 32'(resp_valid), 32'd1);
        chk("add_res", resp_res, 32'h4040_0000);
        chk("add_err", 32'(resp_err), 32'd0);
        chk("add_cyc", 32'(cycles), 32'd0);
        chk("add_rdy", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("add_done_vld", 32'(resp_valid), 32'd0);
        chk("add_done_rdy", 32'(req_ready), 32'd1);

        // mult 2.0 * 3.0 with backpressure
        alu_res = 32'h40C0_0000;
        issue(3'd2, 32'h4000_0000, 32'h4040_0000);
        tick();
        alu_res = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk("mul_bp_vld", 32'(resp_valid), 32'd1);
            chk("mul_bp_res", resp_res, 32'h40C0_0000);
            chk("mul_bp_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        chk("mul_last_rdy", 32'(req_ready), 32'd0);
        tick();
        resp_ready = 1'b0;
        chk("mul_rel_rdy", 32'(req_ready), 32'd1);
        chk("mul_rel_vld", 32'(resp_valid), 32'd0);

        // sine with one stale Done cycle at the start of WAIT
        alu_done = 1'b1;
        alu_res  = 32'hAAAA_AAAA;
        issue(3'd5, 32'd10, 32'h3F00_0000);
        tick();
        chk("sin_w1_vld", 32'(resp_valid), 32'd0);
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("sin_w_vld", 32'(resp_valid), 32'd0);
            chk("sin_w_a", alu_a, 32'd10);
            chk("sin_w_b", alu_b, 32'h3F00_0000);
            chk("sin_w_op", 32'(alu_op), 32'd5);
            tick();
        end
        alu_done = 1'b1;
        alu_res  = 32'h3EF5_7744;
        tick();
        chk("sin_vld", 32'(resp_valid), 32'd1);
        chk("sin_res", resp_res, 32'h3EF5_7744);
        chk("sin_err", 32'(resp_err), 32'd0);
        chk("sin_cyc", 32'(cycles), 32'd22);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // illegal op
        issue(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        chk("ill_vld", 32'(resp_valid), 32'd1);
        chk("ill_err", 32'(resp_err), 32'd1);
        chk("ill_res", resp_res, 32'd0);
        chk("ill_cyc", 32'(cycles), 32'd0);
        chk("ill_op", 32'(alu_op), 32'd5);
        chk("ill_a", alu_a, 32'd10);
        chk("ill_b", alu_b, 32'h3F00_0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("ill_rel_rdy", 32'(req_ready), 32'd1);

        // timeout with Done stuck low
        alu_done = 1'b0;
        alu_res  = 32'h5555_5555;
        issue(3'd5, 32'd3, 32'h0000_0000);
        tick();
        cnt = 0;
        while (!resp_valid && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("tmo_wait", 32'(cnt), 32'd1023);
        chk("tmo_err", 32'(resp_err), 32'd1);
        chk("tmo_res", resp_res, 32'd0);
        chk("tmo_cyc", 32'(cycles), 32'd1023);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        alu_done = 1'b1;
        chk("tmo_next_rdy", 32'(req_ready), 32'd1);
        alu_res = 32'h40A0_0000;
        issue(3'd1, 32'h40E0_0000, 32'h4000_0000);
        tick();
        chk("tmo_next_vld", 32'(resp_valid), 32'd1);
        chk("tmo_next_res", resp_res, 32'h40A0_0000);
        chk("tmo_next_cyc", 32'(cycles), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // reset during WAIT cycle 5
        alu_done = 1'b0;
        issue(3'd5, 32'd7, 32'h3F80_0000);
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("rsw_busy", 32'(busy), 32'd1);
        held = alu_a;
        chk("rsw_a", held, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rsw_vld", 32'(resp_valid), 32'd0);
        chk("rsw_rdy", 32'(req_ready), 32'd1);
        chk("rsw_busy0", 32'(busy), 32'd0);
        chk("rsw_alu_a", alu_a, 32'd0);
        chk("rsw_alu_b", alu_b, 32'd0);
        chk("rsw_alu_op", 32'(alu_op), 32'd0);
        alu_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (resp_valid) seen = 1'b1;
            tick();
        end
        chk("rsw_no_resp", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
